// File: rtl/alu_reservation_station.sv
// alu_reservation_station
//   Tomasulo reservation station on the issuing side of the ALU operand port.
//   It buffers dispatched ALU ops and snoops the CDB for missing operands and
//   flags. Each cycle it issues at most one fully-ready op through registered
//   outputs.
//
//   Optional feature macro: OLDEST_FIRST_EN
//     defined     -> the oldest ready entry issues (per-entry age counters)
//     not defined -> the lowest-index ready entry issues (fixed priority)
//
// Ports
//   clk, rst (async, active-low)           clock / reset
//   in_flush                               synchronous squash of all entries
//   in_dispatch_valid / out_dispatch_ready dispatch handshake
//   in_alu_op, in_val_a/b, in_a/b_ready, in_a/b_tag, in_alu_val_hw,
//   in_set_CC, in_cond, in_nzcv, in_nzcv_ready, in_nzcv_tag, in_dst_tag
//                                          dispatched op fields
//   in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_set_nzcv, in_cdb_nzcv
//                                          common data bus broadcast
//   in_fu_ready                            ALU can accept an op this cycle
//   out_issue_valid, out_alu_op, out_val_a, out_val_b, out_alu_val_hw,
//   out_set_CC, out_cond, out_prev_nzcv, out_dst_tag
//                                          registered issue port
module alu_reservation_station #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 4,
  parameter int OP_W        = 4,
  parameter int COND_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_flush,
  input  logic              in_dispatch_valid,
  output logic              out_dispatch_ready,
  input  logic [OP_W-1:0]   in_alu_op,
  input  logic [63:0]       in_val_a,
  input  logic [63:0]       in_val_b,
  input  logic              in_a_ready,
  input  logic              in_b_ready,
  input  logic [TAG_W-1:0]  in_a_tag,
  input  logic [TAG_W-1:0]  in_b_tag,
  input  logic [5:0]        in_alu_val_hw,
  input  logic              in_set_CC,
  input  logic [COND_W-1:0] in_cond,
  input  logic [3:0]        in_nzcv,
  input  logic              in_nzcv_ready,
  input  logic [TAG_W-1:0]  in_nzcv_tag,
  input  logic [TAG_W-1:0]  in_dst_tag,
  input  logic              in_cdb_valid,
  input  logic [TAG_W-1:0]  in_cdb_tag,
  input  logic [63:0]       in_cdb_value,
  input  logic              in_cdb_set_nzcv,
  input  logic [3:0]        in_cdb_nzcv,
  input  logic              in_fu_ready,
  output logic              out_issue_valid,
  output logic [OP_W-1:0]   out_alu_op,
  output logic [63:0]       out_val_a,
  output logic [63:0]       out_val_b,
  output logic [5:0]        out_alu_val_hw,
  output logic              out_set_CC,
  output logic [COND_W-1:0] out_cond,
  output logic [3:0]        out_prev_nzcv,
  output logic [TAG_W-1:0]  out_dst_tag
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [NUM_ENTRIES-1:0] valid, a_rdy, b_rdy, n_rdy, e_set_cc;
  logic [OP_W-1:0]        e_op    [NUM_ENTRIES];
  logic [63:0]            e_val_a [NUM_ENTRIES];
  logic [63:0]            e_val_b [NUM_ENTRIES];
  logic [TAG_W-1:0]       e_a_tag [NUM_ENTRIES];
  logic [TAG_W-1:0]       e_b_tag [NUM_ENTRIES];
  logic [TAG_W-1:0]       e_n_tag [NUM_ENTRIES];
  logic [TAG_W-1:0]       e_dst   [NUM_ENTRIES];
  logic [5:0]             e_hw    [NUM_ENTRIES];
  logic [COND_W-1:0]      e_cond  [NUM_ENTRIES];
  logic [3:0]             e_nzcv  [NUM_ENTRIES];
`ifdef OLDEST_FIRST_EN
  // age = number of younger valid entries, so it always fits in IDX_W bits
  logic [IDX_W-1:0]       age     [NUM_ENTRIES];
  logic [IDX_W-1:0]       best_age;
`endif

  logic [NUM_ENTRIES-1:0] ready_vec;
  logic                   free_found, sel_found;
  logic [IDX_W-1:0]       free_idx, sel_idx;
  logic                   do_dispatch, do_issue;
  logic                   d_a_hit, d_b_hit, d_n_hit;

  assign ready_vec = valid & a_rdy & b_rdy & n_rdy;

  // lowest-index free slot; descending scan so the lowest index wins
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

`ifdef OLDEST_FIRST_EN
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    best_age  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (ready_vec[i] && (!sel_found || age[i] > best_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age[i];
      end
    end
  end
`else
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  assign out_dispatch_ready = free_found;
  assign do_dispatch = in_dispatch_valid & free_found & ~in_flush;
  assign do_issue    = in_fu_ready & sel_found & ~in_flush;

  // a broadcast in the dispatch cycle would otherwise be missed by the new entry
  assign d_a_hit = in_cdb_valid & ~in_a_ready & (in_a_tag == in_cdb_tag);
  assign d_b_hit = in_cdb_valid & ~in_b_ready & (in_b_tag == in_cdb_tag);
  assign d_n_hit = in_cdb_valid & in_cdb_set_nzcv & ~in_nzcv_ready &
                   (in_nzcv_tag == in_cdb_tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= '0;
      a_rdy    <= '0;
      b_rdy    <= '0;
      n_rdy    <= '0;
      e_set_cc <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        e_op[i]    <= '0;
        e_val_a[i] <= '0;
        e_val_b[i] <= '0;
        e_a_tag[i] <= '0;
        e_b_tag[i] <= '0;
        e_n_tag[i] <= '0;
        e_dst[i]   <= '0;
        e_hw[i]    <= '0;
        e_cond[i]  <= '0;
        e_nzcv[i]  <= '0;
`ifdef OLDEST_FIRST_EN
        age[i]     <= '0;
`endif
      end
      out_issue_valid <= 1'b0;
      out_alu_op      <= '0;
      out_val_a       <= '0;
      out_val_b       <= '0;
      out_alu_val_hw  <= '0;
      out_set_CC      <= 1'b0;
      out_cond        <= '0;
      out_prev_nzcv   <= '0;
      out_dst_tag     <= '0;
    end else if (in_flush) begin
      valid           <= '0;
      out_issue_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (valid[i] && in_cdb_valid) begin
          if (!a_rdy[i] && e_a_tag[i] == in_cdb_tag) begin
            e_val_a[i] <= in_cdb_value;
            a_rdy[i]   <= 1'b1;
          end
          if (!b_rdy[i] && e_b_tag[i] == in_cdb_tag) begin
            e_val_b[i] <= in_cdb_value;
            b_rdy[i]   <= 1'b1;
          end
          if (in_cdb_set_nzcv && !n_rdy[i] && e_n_tag[i] == in_cdb_tag) begin
            e_nzcv[i] <= in_cdb_nzcv;
            n_rdy[i]  <= 1'b1;
          end
        end
`ifdef OLDEST_FIRST_EN
        // a dispatch ages everyone; an issue removes one younger entry from
        // every older entry's count
        if (valid[i]) begin
          if (do_dispatch && !(do_issue && age[i] > age[sel_idx]))
            age[i] <= age[i] + 1'b1;
          else if (!do_dispatch && do_issue && age[i] > age[sel_idx])
            age[i] <= age[i] - 1'b1;
        end
`endif
      end

      out_issue_valid <= do_issue;
      if (do_issue) begin
        valid[sel_idx] <= 1'b0;
        out_alu_op     <= e_op[sel_idx];
        out_val_a      <= e_val_a[sel_idx];
        out_val_b      <= e_val_b[sel_idx];
        out_alu_val_hw <= e_hw[sel_idx];
        out_set_CC     <= e_set_cc[sel_idx];
        out_cond       <= e_cond[sel_idx];
        out_prev_nzcv  <= e_nzcv[sel_idx];
        out_dst_tag    <= e_dst[sel_idx];
      end

      if (do_dispatch) begin
        valid[free_idx]    <= 1'b1;
        e_op[free_idx]     <= in_alu_op;
        e_val_a[free_idx]  <= d_a_hit ? in_cdb_value : in_val_a;
        a_rdy[free_idx]    <= in_a_ready | d_a_hit;
        e_a_tag[free_idx]  <= in_a_tag;
        e_val_b[free_idx]  <= d_b_hit ? in_cdb_value : in_val_b;
        b_rdy[free_idx]    <= in_b_ready | d_b_hit;
        e_b_tag[free_idx]  <= in_b_tag;
        e_nzcv[free_idx]   <= d_n_hit ? in_cdb_nzcv : in_nzcv;
        n_rdy[free_idx]    <= in_nzcv_ready | d_n_hit;
        e_n_tag[free_idx]  <= in_nzcv_tag;
        e_hw[free_idx]     <= in_alu_val_hw;
        e_set_cc[free_idx] <= in_set_CC;
        e_cond[free_idx]   <= in_cond;
        e_dst[free_idx]    <= in_dst_tag;
`ifdef OLDEST_FIRST_EN
        age[free_idx]      <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
module tb_alu_reservation_station;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_flush = 1'b0, in_dispatch_valid = 1'b0;
  logic        out_dispatch_ready;
  logic [3:0]  in_alu_op = '0;
  logic [63:0] in_val_a = '0, in_val_b = '0;
  logic        in_a_ready = 1'b0, in_b_ready = 1'b0;
  logic [3:0]  in_a_tag = '0, in_b_tag = '0;
  logic [5:0]  in_alu_val_hw = '0;
  logic        in_set_CC = 1'b0;
  logic [3:0]  in_cond = '0, in_nzcv = '0;
  logic        in_nzcv_ready = 1'b0;
  logic [3:0]  in_nzcv_tag = '0, in_dst_tag = '0;
  logic        in_cdb_valid = 1'b0;
  logic [3:0]  in_cdb_tag = '0;
  logic [63:0] in_cdb_value = '0;
  logic        in_cdb_set_nzcv = 1'b0;
  logic [3:0]  in_cdb_nzcv = '0;
  logic        in_fu_ready = 1'b0;
  logic        out_issue_valid;
  logic [3:0]  out_alu_op;
  logic [63:0] out_val_a, out_val_b;
  logic [5:0]  out_alu_val_hw;
  logic        out_set_CC;
  logic [3:0]  out_cond, out_prev_nzcv, out_dst_tag;

  alu_reservation_station #(.NUM_ENTRIES(N), .TAG_W(4), .OP_W(4), .COND_W(4)) dut (
    .clk(clk), .rst(rst), .in_flush(in_flush),
    .in_dispatch_valid(in_dispatch_valid), .out_dispatch_ready(out_dispatch_ready),
    .in_alu_op(in_alu_op), .in_val_a(in_val_a), .in_val_b(in_val_b),
    .in_a_ready(in_a_ready), .in_b_ready(in_b_ready),
    .in_a_tag(in_a_tag), .in_b_tag(in_b_tag), .in_alu_val_hw(in_alu_val_hw),
    .in_set_CC(in_set_CC), .in_cond(in_cond), .in_nzcv(in_nzcv),
    .in_nzcv_ready(in_nzcv_ready), .in_nzcv_tag(in_nzcv_tag), .in_dst_tag(in_dst_tag),
    .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .in_cdb_set_nzcv(in_cdb_set_nzcv), .in_cdb_nzcv(in_cdb_nzcv),
    .in_fu_ready(in_fu_ready), .out_issue_valid(out_issue_valid),
    .out_alu_op(out_alu_op), .out_val_a(out_val_a), .out_val_b(out_val_b),
    .out_alu_val_hw(out_alu_val_hw), .out_set_CC(out_set_CC), .out_cond(out_cond),
    .out_prev_nzcv(out_prev_nzcv), .out_dst_tag(out_dst_tag)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    logic [3:0]  op;
    logic [63:0] a, b;
    bit          ar, br, nr;
    logic [3:0]  at, bt, nt, dst;
    logic [5:0]  hw;
    bit          cc;
    logic [3:0]  cond, nz;
    int          seq;
  } ent_t;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a, b;
    logic [5:0]  hw;
    logic        cc;
    logic [3:0]  cond, nz, dst;
  } iss_t;

  ent_t m[N];
  iss_t sb[$];
  iss_t last;
  bit   exp_issue;
  int   seq_ctr;
  int   total = 0;
  int   bad = 0;

  task automatic clear_model();
    for (int i = 0; i < N; i++) m[i].v = 0;
    sb.delete();
    last = '{default: '0};
    exp_issue = 0;
  endtask

  function automatic bit model_has_free();
    for (int i = 0; i < N; i++) if (!m[i].v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    int   fr, sl;
    iss_t t;
    ent_t e;
    fr = -1;
    for (int i = N - 1; i >= 0; i--) if (!m[i].v) fr = i;
    sl = -1;
    if (in_fu_ready)
      for (int i = 0; i < N; i++)
        if (m[i].v && m[i].ar && m[i].br && m[i].nr) begin
`ifdef OLDEST_FIRST_EN
          if (sl < 0 || m[i].seq < m[sl].seq) sl = i;
`else
          if (sl < 0) sl = i;
`endif
        end
    if (in_flush) begin
      for (int i = 0; i < N; i++) m[i].v = 0;
      exp_issue = 0;
    end else begin
      exp_issue = (sl >= 0);
      if (sl >= 0) begin
        t = '{op: m[sl].op, a: m[sl].a, b: m[sl].b, hw: m[sl].hw, cc: m[sl].cc,
              cond: m[sl].cond, nz: m[sl].nz, dst: m[sl].dst};
        sb.push_back(t);
        last = t;
        m[sl].v = 0;
      end
      if (in_cdb_valid)
        for (int i = 0; i < N; i++) if (m[i].v) begin
          if (!m[i].ar && m[i].at == in_cdb_tag) begin m[i].a = in_cdb_value; m[i].ar = 1; end
          if (!m[i].br && m[i].bt == in_cdb_tag) begin m[i].b = in_cdb_value; m[i].br = 1; end
          if (in_cdb_set_nzcv && !m[i].nr && m[i].nt == in_cdb_tag) begin
            m[i].nz = in_cdb_nzcv; m[i].nr = 1;
          end
        end
      if (in_dispatch_valid && fr >= 0) begin
        e.v = 1; e.op = in_alu_op; e.hw = in_alu_val_hw; e.cc = in_set_CC;
        e.cond = in_cond; e.dst = in_dst_tag; e.seq = seq_ctr++;
        e.at = in_a_tag; e.bt = in_b_tag; e.nt = in_nzcv_tag;
        e.a = in_val_a; e.ar = in_a_ready;
        e.b = in_val_b; e.br = in_b_ready;
        e.nz = in_nzcv; e.nr = in_nzcv_ready;
        if (in_cdb_valid && !e.ar && e.at == in_cdb_tag) begin e.a = in_cdb_value; e.ar = 1; end
        if (in_cdb_valid && !e.br && e.bt == in_cdb_tag) begin e.b = in_cdb_value; e.br = 1; end
        if (in_cdb_valid && in_cdb_set_nzcv && !e.nr && e.nt == in_cdb_tag) begin
          e.nz = in_cdb_nzcv; e.nr = 1;
        end
        m[fr] = e;
      end
    end
  endtask

  initial begin
    seq_ctr = 0;
    clear_model();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) clear_model();
      else model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input iss_t e, input string ctx);
    chk({ctx, "_op"},   out_alu_op,     e.op);
    chk({ctx, "_a"},    out_val_a,      e.a);
    chk({ctx, "_b"},    out_val_b,      e.b);
    chk({ctx, "_hw"},   out_alu_val_hw, e.hw);
    chk({ctx, "_cc"},   out_set_CC,     e.cc);
    chk({ctx, "_cond"}, out_cond,       e.cond);
    chk({ctx, "_nzcv"}, out_prev_nzcv,  e.nz);
    chk({ctx, "_dst"},  out_dst_tag,    e.dst);
  endtask

  initial forever begin
    @(negedge clk);
    chk("issue_valid", out_issue_valid, exp_issue);
    chk("dispatch_ready", out_dispatch_ready, model_has_free());
    if (out_issue_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_underflow actual=issue required=no_issue at %0t", $time);
      end else cmp_out(sb.pop_front(), "issue");
    end else cmp_out(last, "hold");
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    in_flush = 0; in_dispatch_valid = 0; in_cdb_valid = 0; in_cdb_set_nzcv = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic disp(input logic [3:0] op, input logic [63:0] a, input bit ar,
                      input logic [3:0] at, input logic [63:0] b, input bit br,
                      input logic [3:0] bt, input logic [3:0] dst);
    in_dispatch_valid = 1; in_alu_op = op;
    in_val_a = a; in_a_ready = ar; in_a_tag = at;
    in_val_b = b; in_b_ready = br; in_b_tag = bt;
    in_nzcv = 4'h0; in_nzcv_ready = 1; in_nzcv_tag = 4'h0;
    in_alu_val_hw = 6'h0; in_set_CC = 0; in_cond = 4'he; in_dst_tag = dst;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [63:0] val);
    in_cdb_valid = 1; in_cdb_tag = tag; in_cdb_value = val;
    in_cdb_set_nzcv = 0; in_cdb_nzcv = 4'h0;
  endtask

  initial begin
    rst = 0;
    in_fu_ready = 1;
    #32 rst = 1;
    @(posedge clk); #1;

    // single ready op: PLUS with a=1, b=1
    disp(4'h1, 64'd1, 1, 4'h0, 64'd1, 1, 4'h0, 4'h2); tick();
    tick(); tick();

    // b waits on tag 3, woken two cycles later
    disp(4'h2, 64'd4, 1, 4'h0, 64'd0, 0, 4'h3, 4'h5); tick();
    tick();
    cdb(4'h3, 64'd5); tick();
    tick(); tick();

    // fill all entries pending, then one wake
    for (int i = 0; i < N; i++) begin
      disp(4'h3, 64'd10 + 64'(i), 1, 4'h0, 64'd0, 0, 4'(10 + i), 4'(i)); tick();
    end
    tick();
    cdb(4'd11, 64'h1111); tick();
    tick(); tick();
    cdb(4'd10, 64'h10); tick();
    cdb(4'd12, 64'h12); tick();
    cdb(4'd13, 64'h13); tick();
    tick(); tick();

    // dispatch-time bypass
    disp(4'h4, 64'd2, 1, 4'h0, 64'd0, 0, 4'h7, 4'h7);
    cdb(4'h7, 64'd9); tick();
    tick(); tick();

    // flush with three pending entries and a concurrent dispatch
    for (int i = 0; i < 3; i++) begin
      disp(4'h5, 64'd0, 0, 4'h1, 64'd0, 0, 4'h2, 4'(i)); tick();
    end
    disp(4'h6, 64'd3, 1, 4'h0, 64'd3, 1, 4'h0, 4'h9);
    in_flush = 1; tick();
    tick(); tick();

    // reset while entries are buffered
    disp(4'h7, 64'd1, 1, 4'h0, 64'd0, 0, 4'h2, 4'h1); tick();
    disp(4'h8, 64'd1, 1, 4'h0, 64'd2, 1, 4'h0, 4'h2);
    in_fu_ready = 0; tick();
    #3 rst = 0;
    #4 rst = 1;
    in_fu_ready = 1;
    tick(); tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_fu_ready = ($urandom_range(0, 3) != 0);
      in_flush    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 1) begin
        in_dispatch_valid = 1;
        in_alu_op = 4'($urandom); in_dst_tag = 4'($urandom);
        in_val_a = {$urandom, $urandom}; in_a_ready = $urandom_range(0, 1);
        in_a_tag = 4'($urandom_range(0, 7));
        in_val_b = {$urandom, $urandom}; in_b_ready = $urandom_range(0, 1);
        in_b_tag = 4'($urandom_range(0, 7));
        in_nzcv = 4'($urandom); in_nzcv_ready = $urandom_range(0, 1);
        in_nzcv_tag = 4'($urandom_range(0, 7));
        in_alu_val_hw = 6'($urandom); in_set_CC = $urandom_range(0, 1);
        in_cond = 4'($urandom);
      end
      if ($urandom_range(0, 9) < 6) begin
        in_cdb_valid = 1; in_cdb_tag = 4'($urandom_range(0, 7));
        in_cdb_value = {$urandom, $urandom};
        in_cdb_set_nzcv = $urandom_range(0, 1); in_cdb_nzcv = 4'($urandom);
      end
      tick();
    end

    in_flush = 1; tick();
    tick(); tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
